// File: rtl/featurize_pkg.sv
// Shared constants and width helpers for the featurize path.
package featurize_pkg;

  localparam int EPOCH_W        = 8;
  localparam int DEFAULT_WINDOW = 7;

  // Rolling-sum width that cannot overflow for a window of full-scale epochs.
  function automatic int sum_width(input int window, input int data_w);
    return data_w + $clog2(window);
  endfunction

endpackage

// File: rtl/window_shift_reg.sv
// WINDOW x DATA_W epoch shift register; newest enters at the top, oldest leaves at index 0.
// Zero latency on taps; shift happens on the clock edge where shift=1.
module window_shift_reg
  import featurize_pkg::*;
#(
  parameter int WINDOW = DEFAULT_WINDOW,
  parameter int DATA_W = EPOCH_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] evict,
  output logic [DATA_W-1:0] center_next
);

  logic [DATA_W-1:0] win [WINDOW];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < WINDOW; k++) win[k] <= '0;
    end else if (clear) begin
      // A sample arriving with the flush becomes the first entry of the new window.
      for (int k = 0; k < WINDOW - 1; k++) win[k] <= '0;
      win[WINDOW-1] <= shift ? din : '0;
    end else if (shift) begin
      for (int k = 0; k < WINDOW - 1; k++) win[k] <= win[k+1];
      win[WINDOW-1] <= din;
    end
  end

  assign evict = win[0];
  // Entry that becomes win[WINDOW/2] after the next shift.
  assign center_next = win[WINDOW/2 + 1];

endmodule

// File: rtl/epoch_window.sv
// Sliding-window sum and centre epoch; result registered one cycle after i_valid.
// Input has no backpressure: a window completing while the output is stalled is dropped and flagged in o_overrun.
module epoch_window
  import featurize_pkg::*;
#(
  parameter int WINDOW = DEFAULT_WINDOW,
  parameter int DATA_W = EPOCH_W,
  localparam int SUM_W = sum_width(WINDOW, DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_clear,
  output logic [SUM_W-1:0]  o_sum,
  output logic [DATA_W-1:0] o_center,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overrun
);

  localparam int FILL_W = $clog2(WINDOW + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WINDOW);
  localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(WINDOW - 1);

  logic [SUM_W-1:0]  acc, acc_next;
  logic [FILL_W-1:0] fill, fill_next;
  logic [DATA_W-1:0] evict, evicted, center_next;
  logic              complete;

  window_shift_reg #(
    .WINDOW(WINDOW),
    .DATA_W(DATA_W)
  ) u_win (
    .clk        (clk),
    .reset      (reset),
    .clear      (i_clear),
    .shift      (i_valid),
    .din        (i_data),
    .evict      (evict),
    .center_next(center_next)
  );

  always_comb begin
    evicted   = (fill == FILL_MAX) ? evict : '0;
    acc_next  = acc;
    fill_next = fill;
    complete  = 1'b0;
    if (i_clear) begin
      acc_next  = i_valid ? SUM_W'(i_data) : '0;
      fill_next = i_valid ? FILL_W'(1) : '0;
    end else if (i_valid) begin
      // acc always contains evicted, so the subtraction never underflows.
      acc_next  = acc + SUM_W'(i_data) - SUM_W'(evicted);
      fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
      complete  = (fill >= FILL_PRE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      fill      <= '0;
      o_sum     <= '0;
      o_center  <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      acc  <= acc_next;
      fill <= fill_next;
      if (i_clear) begin
        o_valid <= 1'b0;
      end else if (complete) begin
        if (!o_valid || i_ready) begin
          o_sum    <= acc_next;
          o_center <= center_next;
          o_valid  <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_epoch_window.sv
// Directed table-driven bench for epoch_window (WINDOW=7, DATA_W=8).
module tb_epoch_window;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        i_clear;
  logic        i_ready;
  logic [10:0] o_sum;
  logic [7:0]  o_center;
  logic        o_valid;
  logic        o_overrun;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        clr;
    logic        rdy;
    logic        ev;
    logic [10:0] sum;
    logic [7:0]  c;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  epoch_window #(.WINDOW(7), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .i_clear  (i_clear),
    .o_sum    (o_sum),
    .o_center (o_center),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic check_out(input int idx, input logic ev, input int sum, input int c, input logic ov);
    chk("o_valid", idx, int'(o_valid), int'(ev));
    chk("o_sum", idx, int'(o_sum), sum);
    chk("o_center", idx, int'(o_center), c);
    chk("o_overrun", idx, int'(o_overrun), int'(ov));
  endtask

  task automatic add(input logic v, input int d, input logic clr, input logic rdy,
                     input logic ev, input int sum, input int c, input logic ov);
    vec_t r;
    r.v = v; r.d = 8'(d); r.clr = clr; r.rdy = rdy;
    r.ev = ev; r.sum = 11'(sum); r.c = 8'(c); r.ov = ov;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic rst, input logic v, input int d, input logic clr, input logic rdy);
    @(negedge clk);
    reset = rst; i_valid = v; i_data = 8'(d); i_clear = clr; i_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_data = '0; i_clear = 1'b0; i_ready = 1'b1;

    // Warm-up with 1..7, then steady-state rolling.
    for (int i = 1; i <= 6; i++) add(1, i, 0, 1, 0, 0, 0, 0);
    add(1, 7, 0, 1, 1, 28, 4, 0);
    add(0, 0, 0, 1, 0, 28, 4, 0);      // consumed, data held
    add(1, 8, 0, 1, 1, 35, 5, 0);
    add(1, 0, 0, 1, 1, 33, 6, 0);
    // 255s back to back: window [3..8,0] -> all 255
    add(1, 255, 0, 1, 1, 285, 7, 0);
    add(1, 255, 0, 1, 1, 536, 8, 0);
    add(1, 255, 0, 1, 1, 786, 0, 0);
    add(1, 255, 0, 1, 1, 1035, 255, 0);
    add(1, 255, 0, 1, 1, 1283, 255, 0);
    add(1, 255, 0, 1, 1, 1530, 255, 0);
    add(1, 255, 0, 1, 1, 1785, 255, 0);
    add(0, 0, 0, 1, 0, 1785, 255, 0);
    // Stall: 10 loads, 20 is dropped and the held result stays put.
    add(1, 10, 0, 0, 1, 1540, 255, 0);
    add(1, 20, 0, 0, 1, 1540, 255, 1);
    add(0, 0, 0, 0, 1, 1540, 255, 1);
    add(0, 0, 0, 1, 0, 1540, 255, 1);
    add(0, 0, 0, 1, 0, 1540, 255, 1);
    // Three more inputs, then flush with a sample arriving the same cycle.
    add(1, 1, 0, 1, 1, 1051, 255, 1);
    add(1, 2, 0, 1, 1, 798, 10, 1);
    add(1, 3, 0, 1, 1, 546, 20, 1);
    add(1, 9, 1, 1, 0, 546, 20, 1);
    for (int i = 0; i < 5; i++) add(1, 1, 0, 1, 0, 546, 20, 1);
    add(1, 1, 0, 1, 1, 15, 1, 1);
    add(0, 0, 0, 1, 0, 15, 1, 1);

    repeat (2) @(posedge clk);
    #1;
    check_out(-1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, vecs[i].v, int'(vecs[i].d), vecs[i].clr, vecs[i].rdy);
      check_out(i, vecs[i].ev, int'(vecs[i].sum), int'(vecs[i].c), vecs[i].ov);
    end

    // Reset mid-fill with i_valid high clears everything, including the sticky flag.
    drive(0, 1, 4, 0, 1);
    drive(0, 1, 5, 0, 1);
    drive(1, 1, 6, 0, 1);
    check_out(100, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 2, 0, 1);
      check_out(101 + i, 0, 0, 0, 0);
    end
    drive(0, 1, 2, 0, 1);
    check_out(107, 1, 14, 2, 0);
    drive(0, 0, 0, 0, 1);
    check_out(108, 0, 14, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/epoch_window.md
# epoch_window

Sliding-window feature stage directly downstream of the per-epoch activity summer in the featurize path. Consumes one epoch activity count per `i_valid` pulse and keeps the last WINDOW counts in a shift register. Once the window is full it emits, on every new epoch, the rolling window sum and the centre epoch value through a registered valid/ready output to the sleep/wake classifier. Stalls and drops are reported on a sticky overrun flag because the upstream stage has no backpressure.

## Interface
- WINDOW, 7: epochs per window; odd, 3..31.
- DATA_W, 8: width of each epoch count.
- SUM_W (localparam), DATA_W + $clog2(WINDOW): rolling-sum width; guarantees no overflow.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- i_data  in  DATA_W  epoch count, sampled when i_valid=1.
- i_valid  in  1  single-cycle strobe, one per epoch; no ready returned.
- i_clear  in  1  synchronous window flush (start of recording).
- o_sum  out  SUM_W  sum of the WINDOW most recent epochs.
- o_center  out  DATA_W  epoch at index WINDOW/2 (oldest = 0).
- o_valid  out  1  output register holds an unconsumed result.
- i_ready  in  1  downstream accepts; transfer when o_valid && i_ready.
- o_overrun  out  1  sticky: a completed window was dropped.

## Operation
- Shift register win[0..WINDOW-1]: on accepted input, win[WINDOW-1] ← i_data and each win[k] ← win[k+1]; the old win[0] is evicted.
- Rolling sum: acc ← acc + i_data − evicted, where evicted = win[0] if fill == WINDOW, else 0. No full re-add.
- fill counter 0..WINDOW, increments per input and saturates at WINDOW.
- Window complete: an input arrives and fill is WINDOW−1 or WINDOW before the update.
- Output register load on window complete if !o_valid or (o_valid && i_ready) in the same cycle: o_sum ← new acc, o_center ← new win[WINDOW/2], o_valid ← 1.
- Window complete while o_valid && !i_ready: the result is dropped and the output register is held. o_overrun ← 1. The window and acc still update.
- Consume without a new load: o_valid ← 0, data held.
- i_clear: win, acc and fill ← 0, o_valid ← 0, o_overrun unchanged.
- i_clear together with i_valid: clear first, then the sample becomes the first entry (fill=1, acc=i_data).
- Reset: win, acc, fill, o_sum, o_center ← 0; o_valid, o_overrun ← 0.

## Timing
- Latency: input sampled at edge N, o_valid and data visible after edge N. Result appears in the cycle after the i_valid cycle.
- Throughput: one input per cycle is supported, although epochs normally arrive ≥15 cycles apart.
- o_sum and o_center are stable while o_valid=1 and i_ready=0.
- Warm-up: the first WINDOW−1 inputs after reset or clear produce no o_valid.
- Reset asserted mid-operation overrides everything in that cycle, including i_valid and i_ready.

## Structure
- Shared featurize_pkg: EPOCH_W=8 constant, default WINDOW, and a sum_width(window, data_w) function used for SUM_W.
- One sub-module, window_shift_reg: parameterised WINDOW×DATA_W shift register exposing win[0] (evicted) and win[WINDOW/2].
- Fill counter, accumulator and output register stay in epoch_window.

## Test plan
- WINDOW=7, i_ready=1, inputs 1..7 → no o_valid for the first 6. After the 7th: o_sum=28, o_center=4.
- Continue with input 8 → o_sum=35, o_center=5. Input 0 → o_sum=33, o_center=6.
- Seven inputs of 255 → o_sum=1785 (11 bits, no wrap), o_center=255.
- Full window, i_ready=0, two further inputs 10 and 20 → first result held unchanged, o_overrun=1 after the second. Raise i_ready → one transfer, then o_valid=0.
- Three inputs, then i_clear with i_valid, i_data=9, then six inputs of 1 → o_valid only after those six, o_sum=15.
- Reset asserted mid-fill with i_valid high → all outputs 0 next cycle, and a fresh 7 inputs are needed before o_valid.
